// File: rtl/branch_pred_unit.sv
// -----------------------------------------------------------------------------
// branch_pred_unit
//   Bimodal branch predictor (table of 2-bit saturating counters) combined with
//   the branch resolve stage: evaluates the branch condition, computes the
//   target, detects mispredicts and issues a registered one-cycle redirect.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   pred_pc_i / pred_taken_o  fetch-side lookup (combinational table read)
//   res_valid_i, stall_i      resolve request valid, pipeline stall (hold)
//   sel_i                     branch kind (BEQ..BGEU, J; 7 = not a branch)
//   data1_i, data2_i          compare operands; data1_i is also the JALR base
//   pc_i, imm_i, is_jalr_i    branch PC, offset, JALR select
//   pred_taken_i              prediction made for this branch at fetch
//   redirect_o, redirect_addr_o  registered redirect pulse and target
//   br_cnt_o, miss_cnt_o      resolved-branch and mispredict counters
// -----------------------------------------------------------------------------
module branch_pred_unit #(
   parameter int XLEN      = 32,
   parameter int AW        = 16,
   parameter int BHT_DEPTH = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   pred_pc_i,
   output logic            pred_taken_o,
   input  logic            res_valid_i,
   input  logic            stall_i,
   input  logic [2:0]      sel_i,
   input  logic [XLEN-1:0] data1_i,
   input  logic [XLEN-1:0] data2_i,
   input  logic [AW-1:0]   pc_i,
   input  logic [AW-1:0]   imm_i,
   input  logic            is_jalr_i,
   input  logic            pred_taken_i,
   output logic            redirect_o,
   output logic [AW-1:0]   redirect_addr_o,
   output logic [31:0]     br_cnt_o,
   output logic [31:0]     miss_cnt_o
);

   localparam int IW = $clog2(BHT_DEPTH);

   typedef enum logic [2:0] {
      BR_BEQ  = 3'd0,
      BR_BNE  = 3'd1,
      BR_BLT  = 3'd2,
      BR_BGE  = 3'd3,
      BR_BLTU = 3'd4,
      BR_BGEU = 3'd5,
      BR_J    = 3'd6,
      BR_NONE = 3'd7
   } br_sel_e;

   logic [1:0]    bht_q [BHT_DEPTH];
   logic          redirect_q;
   logic [AW-1:0] redirect_addr_q;
   logic [31:0]   br_cnt_q,  br_cnt_d;
   logic [31:0]   miss_cnt_q, miss_cnt_d;

   br_sel_e       sel;
   logic          is_branch, is_cond, shadow, accept, taken, mispredict;
   logic [AW-1:0] jalr_sum, target, fall_thru, redirect_addr_d;
   logic [IW-1:0] pred_idx, upd_idx;
   logic [1:0]    ctr_cur, ctr_d;

   // Low PC bits and bits above the index do not address the table.
   logic unused_pred_pc;
   assign unused_pred_pc = ^{pred_pc_i[1:0], pred_pc_i[AW-1:IW+2]};

   assign sel      = br_sel_e'(sel_i);
   assign pred_idx = pred_pc_i[IW+1:2];
   assign upd_idx  = pc_i[IW+1:2];

   // Plain read of the registered table: a same-cycle update to the same
   // entry is not visible until the next cycle.
   assign pred_taken_o = bht_q[pred_idx][1];

   // The cycle carrying a redirect is the shadow of the mispredicted branch;
   // anything presented then is on the wrong path and is discarded.
   assign shadow    = redirect_q;
   assign is_branch = (sel != BR_NONE);
   assign is_cond   = is_branch && (sel != BR_J);
   assign accept    = res_valid_i && !stall_i && !shadow && is_branch;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      taken = 1'b0;
      unique case (sel)
         BR_BEQ:  taken = (data1_i == data2_i);
         BR_BNE:  taken = (data1_i != data2_i);
         BR_BLT:  taken = ($signed(data1_i) <  $signed(data2_i));
         BR_BGE:  taken = ($signed(data1_i) >= $signed(data2_i));
         BR_BLTU: taken = (data1_i <  data2_i);
         BR_BGEU: taken = (data1_i >= data2_i);
         BR_J:    taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

   assign jalr_sum   = data1_i[AW-1:0] + imm_i;
   assign target     = is_jalr_i ? {jalr_sum[AW-1:1], 1'b0} : (pc_i + imm_i);
   assign fall_thru  = pc_i + AW'(4);
   assign mispredict = accept && (taken != pred_taken_i);

   always_comb begin
      ctr_cur = bht_q[upd_idx];
      ctr_d   = ctr_cur;
      if (taken && ctr_cur != 2'b11)
         ctr_d = ctr_cur + 2'd1;
      else if (!taken && ctr_cur != 2'b00)
         ctr_d = ctr_cur - 2'd1;
   end

   assign redirect_addr_d = mispredict ? (taken ? target : fall_thru) : redirect_addr_q;
   assign br_cnt_d        = br_cnt_q   + 32'(accept);
   assign miss_cnt_d      = miss_cnt_q + 32'(mispredict);

   // NOTE: the counter table is reset explicitly because a cold predictor must
   // start weakly not-taken; this forces it into flops rather than a RAM macro.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
         redirect_q      <= 1'b0;
         redirect_addr_q <= '0;
         br_cnt_q        <= '0;
         miss_cnt_q      <= '0;
      end else begin
         // NOTE: state uses non-blocking assignments so every flop samples
         // the pre-edge values regardless of statement order.
         if (accept && is_cond) bht_q[upd_idx] <= ctr_d;
         redirect_q      <= mispredict;
         redirect_addr_q <= redirect_addr_d;
         br_cnt_q        <= br_cnt_d;
         miss_cnt_q      <= miss_cnt_d;
      end
   end

   assign redirect_o      = redirect_q;
   assign redirect_addr_o = redirect_addr_q;
   assign br_cnt_o        = br_cnt_q;
   assign miss_cnt_o      = miss_cnt_q;

endmodule

// File: tb/tb_branch_pred_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_pred_unit
//   Self-checking bench for branch_pred_unit. Each driven cycle runs a
//   reference model; the expected post-edge outputs go into a scoreboard queue
//   and are popped and compared one time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_branch_pred_unit;

   localparam int XLEN = 32;
   localparam int AW   = 16;
   localparam int BHT  = 64;

   localparam logic [2:0] BEQ = 3'd0, BNE = 3'd1, BLT = 3'd2, BGE = 3'd3,
                          BLTU = 3'd4, BGEU = 3'd5, JMP = 3'd6, NONE = 3'd7;

   logic            clk = 1'b0;
   logic            rst;
   logic [AW-1:0]   pred_pc_i;
   logic            pred_taken_o;
   logic            res_valid_i, stall_i;
   logic [2:0]      sel_i;
   logic [XLEN-1:0] data1_i, data2_i;
   logic [AW-1:0]   pc_i, imm_i;
   logic            is_jalr_i, pred_taken_i;
   logic            redirect_o;
   logic [AW-1:0]   redirect_addr_o;
   logic [31:0]     br_cnt_o, miss_cnt_o;

   branch_pred_unit #(.XLEN(XLEN), .AW(AW), .BHT_DEPTH(BHT)) dut (
      .clk(clk), .rst(rst),
      .pred_pc_i(pred_pc_i), .pred_taken_o(pred_taken_o),
      .res_valid_i(res_valid_i), .stall_i(stall_i), .sel_i(sel_i),
      .data1_i(data1_i), .data2_i(data2_i),
      .pc_i(pc_i), .imm_i(imm_i), .is_jalr_i(is_jalr_i),
      .pred_taken_i(pred_taken_i),
      .redirect_o(redirect_o), .redirect_addr_o(redirect_addr_o),
      .br_cnt_o(br_cnt_o), .miss_cnt_o(miss_cnt_o)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic          redirect;
      logic [AW-1:0] addr;
      logic [31:0]   br;
      logic [31:0]   miss;
   } exp_t;

   exp_t          sb_q[$];
   logic [1:0]    m_bht [BHT];
   logic          m_redirect;
   logic [AW-1:0] m_addr;
   logic [31:0]   m_br, m_miss;

   task automatic model_reset();
      for (int i = 0; i < BHT; i++) m_bht[i] = 2'b01;
      m_redirect = 1'b0;
      m_addr     = '0;
      m_br       = '0;
      m_miss     = '0;
   endtask

   // One clock of stimulus: drive at the falling edge, check the combinational
   // prediction, push the expected registered state, compare after the edge.
   task automatic drive(input logic v, input logic st, input logic [2:0] s,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic [AW-1:0] pc, input logic [AW-1:0] imm,
                        input logic jr, input logic ptk, input logic [AW-1:0] ppc);
      logic          acc, tk, mis;
      logic [AW-1:0] tgt, js;
      logic [5:0]    ix;
      exp_t          e;
      @(negedge clk);
      res_valid_i = v;  stall_i = st; sel_i = s;
      data1_i = d1;     data2_i = d2; pc_i = pc; imm_i = imm;
      is_jalr_i = jr;   pred_taken_i = ptk; pred_pc_i = ppc;
      #1;
      check("pred_taken", {31'd0, pred_taken_o}, {31'd0, m_bht[ppc[7:2]][1]});

      case (s)
         BEQ:     tk = (d1 == d2);
         BNE:     tk = (d1 != d2);
         BLT:     tk = ($signed(d1) < $signed(d2));
         BGE:     tk = !($signed(d1) < $signed(d2));
         BLTU:    tk = (d1 < d2);
         BGEU:    tk = !(d1 < d2);
         JMP:     tk = 1'b1;
         default: tk = 1'b0;
      endcase
      acc = v && !st && !m_redirect && (s != NONE);
      mis = acc && (tk != ptk);
      js  = d1[AW-1:0] + imm;
      tgt = jr ? (js & ~16'h0001) : (pc + imm);
      ix  = pc[7:2];
      if (acc && s != JMP) begin
         if (tk && m_bht[ix] != 2'd3)       m_bht[ix] = m_bht[ix] + 2'd1;
         else if (!tk && m_bht[ix] != 2'd0) m_bht[ix] = m_bht[ix] - 2'd1;
      end
      if (mis) m_addr = tk ? tgt : (pc + 16'd4);
      m_redirect = mis;
      m_br   = m_br + (acc ? 32'd1 : 32'd0);
      m_miss = m_miss + (mis ? 32'd1 : 32'd0);
      e.redirect = m_redirect; e.addr = m_addr; e.br = m_br; e.miss = m_miss;
      sb_q.push_back(e);

      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check("redirect",      {31'd0, redirect_o},      {31'd0, e.redirect});
      check("redirect_addr", {16'd0, redirect_addr_o}, {16'd0, e.addr});
      check("br_cnt",        br_cnt_o,                 e.br);
      check("miss_cnt",      miss_cnt_o,               e.miss);
   endtask

   task automatic idle(input logic [AW-1:0] ppc);
      drive(1'b0, 1'b0, NONE, 32'd0, 32'd0, 16'd0, 16'd0, 1'b0, 1'b0, ppc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      res_valid_i = 0; stall_i = 0; sel_i = NONE; data1_i = 0; data2_i = 0;
      pc_i = 0; imm_i = 0; is_jalr_i = 0; pred_taken_i = 0; pred_pc_i = 0;
      model_reset();
      #23;
      check("rst_redirect", {31'd0, redirect_o}, 32'd0);
      check("rst_addr",     {16'd0, redirect_addr_o}, 32'd0);
      check("rst_br",       br_cnt_o, 32'd0);
      check("rst_miss",     miss_cnt_o, 32'd0);
      check("rst_pred",     {31'd0, pred_taken_o}, 32'd0);
      @(posedge clk); #3 rst = 1'b1;

      // Taken BEQ predicted not-taken: redirect to pc+imm, counter 01 -> 10.
      drive(1, 0, BEQ, 32'd5, 32'd5, 16'h0100, 16'h0020, 0, 0, 16'h0100);
      check("beq_addr_const", {16'd0, redirect_addr_o}, 32'h0120);
      idle(16'h0100);            // shadow cycle; prediction at index 0 now taken

      // Signed vs unsigned compare of the same operands.
      drive(1, 0, BLT,  32'hFFFF_FFFF, 32'd1, 16'h0200, 16'h0010, 0, 1, 16'h0200);
      drive(1, 0, BLTU, 32'hFFFF_FFFF, 32'd1, 16'h0204, 16'h0010, 0, 0, 16'h0204);
      drive(1, 0, BGEU, 32'hFFFF_FFFF, 32'd1, 16'h0208, 16'h0010, 0, 1, 16'h0208);

      // Four taken BNE at 0x0040 saturate the counter; predict at the same
      // index in the update cycle to observe the pre-update value.
      for (int i = 0; i < 4; i++)
         drive(1, 0, BNE, 32'd1, 32'd2, 16'h0040, 16'h0008, 0, 1, 16'h0040);
      idle(16'h0040);
      drive(1, 0, BNE, 32'd3, 32'd3, 16'h0040, 16'h0008, 0, 1, 16'h0040);
      idle(16'h0040);            // counter 2: still predicts taken

      // JALR with odd sum clears bit 0; the following shadow request is dropped.
      drive(1, 0, JMP, 32'h0000_1233, 32'd0, 16'h0300, 16'h0002, 1, 0, 16'h0300);
      drive(1, 0, BEQ, 32'd7, 32'd7, 16'h0310, 16'h0040, 0, 0, 16'h0310);
      idle(16'h0000);

      // Mispredicting BGE held by stall for 3 cycles with operands wandering.
      drive(1, 1, BGE, 32'd9, 32'd5, 16'h0400, 16'h0010, 0, 1, 16'h0400);
      drive(1, 1, BGE, 32'd1, 32'd0, 16'h0400, 16'h0010, 0, 1, 16'h0400);
      drive(1, 1, BGE, 32'd6, 32'd5, 16'h0400, 16'h0010, 0, 1, 16'h0400);
      drive(1, 0, BGE, 32'd1, 32'd5, 16'h0400, 16'h0010, 0, 1, 16'h0400);
      idle(16'h0400);

      // Address wrap on target and fall-through, plus a J predicted taken.
      drive(1, 0, BEQ, 32'd0, 32'd0, 16'hFFF0, 16'h0020, 0, 0, 16'hFFF0);
      idle(16'h0000);
      drive(1, 0, BNE, 32'd4, 32'd4, 16'hFFFE, 16'h0020, 0, 1, 16'hFFFE);
      idle(16'h0000);
      drive(1, 0, JMP, 32'd0, 32'd0, 16'h0500, 16'h0100, 0, 1, 16'h0500);

      // Random traffic over a small set of indices.
      for (int i = 0; i < 60; i++)
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
               3'($urandom_range(0, 7)), $urandom_range(0, 3) - 32'd1,
               $urandom_range(0, 3), 16'($urandom_range(0, 15) << 2),
               16'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 16'($urandom_range(0, 15) << 2));
      idle(16'h0000);

      // Reset asserted in the cycle a mispredict is accepted.
      @(negedge clk);
      res_valid_i = 1; stall_i = 0; sel_i = BEQ; data1_i = 1; data2_i = 1;
      pc_i = 16'h0600; imm_i = 16'h0010; is_jalr_i = 0; pred_taken_i = 0;
      #2 rst = 1'b0;
      model_reset();
      #1;
      check("mid_rst_br",   br_cnt_o, m_br);
      check("mid_rst_miss", miss_cnt_o, m_miss);
      @(posedge clk); #1;
      check("mid_rst_redirect", {31'd0, redirect_o}, {31'd0, m_redirect});
      check("mid_rst_addr",     {16'd0, redirect_addr_o}, {16'd0, m_addr});
      res_valid_i = 0; sel_i = NONE;
      for (int i = 0; i < BHT; i++) begin
         pred_pc_i = 16'(i << 2);
         #0.1;
         check("mid_rst_table", {31'd0, pred_taken_o}, 32'd0);
      end
      @(posedge clk); #3 rst = 1'b1;

      // First accept on the first edge after reset release.
      drive(1, 0, BGEU, 32'd3, 32'd2, 16'h0600, 16'h0010, 0, 0, 16'h0600);
      idle(16'h0600);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
